// File: rtl/aurora_bus_arbiter.sv
// Four-requester round-robin arbiter and fixed-length burst sequencer for the Aurora local word bus.
// Define ARB_TIMEOUT_EN to abort transfers that stall for TIMEOUT cycles in REQ or DATA.
module aurora_bus_arbiter #(
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_w_1,
  input  logic        req_w_2,
  input  logic        req_r_1,
  input  logic        req_r_2,
  input  logic [31:0] wr_dat_1,
  input  logic [31:0] wr_dat_2,
  input  logic        wr_vld_1,
  input  logic        wr_vld_2,
  output logic        wr_take,
  output logic [31:0] rd_dat,
  output logic        rd_vld,
  output logic [3:0]  gnt,
  output logic        done,
  output logic        err,
  output logic        stb,
  output logic        we,
  input  logic        ack,
  output logic        m_rdy,
  output logic [31:0] dat_o,
  input  logic        s_rdy,
  input  logic [31:0] dat_i,
  output logic        abort,
  output logic [2:0]  state_dbg
);

  // Handshakes: a write beat is a cycle where wr_take is high (the granted writer's
  // wr_vld with beats remaining, in DATA); m_rdy/dat_o present it one cycle later.
  // A read beat is a cycle in DATA where s_rdy is high; rd_vld/rd_dat follow one cycle later.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    DATA  = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } state_t;

  localparam logic [7:0] BL    = 8'(BURST_LEN);
  localparam logic [7:0] BL_M1 = 8'(BURST_LEN - 1);

  if (BURST_LEN < 1 || BURST_LEN > 255 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_param
    $error("aurora_bus_arbiter: BURST_LEN or TIMEOUT out of range");
  end

  state_t      state, state_nxt;
  logic [3:0]  req;
  logic [1:0]  ptr;
  logic [1:0]  gidx;
  logic [1:0]  win_idx;
  logic        win_vld;
  logic [7:0]  beat_cnt;
  logic        beats_left;
  logic        wr_vld_sel;
  logic [31:0] wr_dat_sel;
  logic        rd_beat;
  logic        beat;
  logic        timeout_hit;

  assign req        = {req_r_2, req_r_1, req_w_2, req_w_1};
  assign beats_left = (beat_cnt < BL);
  assign wr_vld_sel = gidx[0] ? wr_vld_2 : wr_vld_1;
  assign wr_dat_sel = gidx[0] ? wr_dat_2 : wr_dat_1;
  assign wr_take    = (state == DATA) && we && beats_left && wr_vld_sel;
  assign rd_beat    = (state == DATA) && !we && beats_left && s_rdy;
  assign beat       = wr_take | rd_beat;
  assign state_dbg  = state;
  assign done       = (state == DONE);

  // Scan from the highest offset down so the requester closest after ptr wins.
  always_comb begin : rr_pick
    logic [1:0] cand;
    cand    = ptr;
    win_vld = 1'b0;
    win_idx = ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [15:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || !(state == REQ || state == DATA) || (state == REQ && ack) || beat)
      wait_cnt <= '0;
    else
      wait_cnt <= wait_cnt + 16'd1;
  end

  assign timeout_hit = (wait_cnt == 16'(TIMEOUT - 1)) && !beat;
  assign abort       = (state == ABORT);
  assign err         = (state == ABORT);
`else
  assign timeout_hit = 1'b0;
  assign abort       = 1'b0;
  assign err         = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (win_vld) state_nxt = REQ;
      REQ: begin
        if (ack)              state_nxt = DATA;
        else if (timeout_hit) state_nxt = ABORT;
      end
      DATA: begin
        if ((we && !beats_left) || (rd_beat && beat_cnt == BL_M1)) state_nxt = DONE;
        else if (timeout_hit)                                      state_nxt = ABORT;
      end
      DONE:    state_nxt = IDLE;
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      gidx     <= 2'd0;
      gnt      <= 4'd0;
      stb      <= 1'b0;
      we       <= 1'b0;
      beat_cnt <= 8'd0;
      m_rdy    <= 1'b0;
      dat_o    <= 32'd0;
      rd_dat   <= 32'd0;
      rd_vld   <= 1'b0;
    end else begin
      state  <= state_nxt;
      m_rdy  <= wr_take;
      rd_vld <= rd_beat;
      if (wr_take) dat_o  <= wr_dat_sel;
      if (rd_beat) rd_dat <= dat_i;
      case (state)
        IDLE: if (win_vld) begin
          gidx <= win_idx;
          gnt  <= 4'b0001 << win_idx;
          stb  <= 1'b1;
          we   <= ~win_idx[1];
        end
        REQ:     if (ack) beat_cnt <= 8'd0;
        DATA:    if (beat) beat_cnt <= beat_cnt + 8'd1;
        default: ;
      endcase
      // Leaving a grant (completed or aborted) releases the bus and moves the pointer on.
      if (state_nxt == DONE || state_nxt == ABORT) begin
        gnt <= 4'd0;
        stb <= 1'b0;
        we  <= 1'b0;
        ptr <= gidx + 2'd1;
      end
    end
  end

endmodule
